// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 Set 2 scan-code bytes into menu/game key pulses, held levels and last-held keycode
module ps2_key_decoder #(
  parameter int PREFIX_TIMEOUT = 2000000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] key,
  output logic [5:0] key_held,
  output logic [7:0] keycode,
  output logic       keycode_ext
);
  localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(PREFIX_TIMEOUT - 1);
  localparam logic [CW-1:0] SAT = CW'(PREFIX_TIMEOUT);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0] key_nxt, held_nxt, hit;
  logic [7:0] kc_nxt;
  logic kx_nxt, ext, do_make, do_brk, ignored, fake, clr;
  function automatic logic [5:0] map_key(input logic [7:0] c, input logic e);
    return e ? {2'b00, c == 8'h74, c == 8'h6B, c == 8'h72, c == 8'h75}
             : {c == 8'h76, c == 8'h5A, 4'b0000};
  endfunction
  // prefix tracking, prefix timeout and the make/break effect on the key outputs
  always_comb begin
    ignored = rx_data inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00};
    fake = rx_data inside {8'h12, 8'h59};
    ext = state == EXT || state == EXT_BRK;
    state_nxt = state;
    do_make = 1'b0;
    do_brk = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          state_nxt = rx_data == 8'hE0 ? EXT : rx_data == 8'hF0 ? BRK : IDLE;
          do_make = rx_data != 8'hE0 && rx_data != 8'hF0 && !ignored;
        end
        EXT: begin
          state_nxt = rx_data == 8'hF0 ? EXT_BRK : IDLE;
          do_make = rx_data != 8'hF0 && !fake;
        end
        default: begin
          state_nxt = IDLE;
          do_brk = 1'b1;
        end
      endcase
    end else if (state != IDLE && cnt == TERM) begin
      state_nxt = IDLE;
    end
    cnt_nxt = (rx_valid || state == IDLE) ? '0 : cnt == SAT ? cnt : cnt + CW'(1);
    hit = map_key(rx_data, ext);
    clr = do_brk && rx_data == keycode && ext == keycode_ext;
    key_nxt = do_make ? hit & ~key_held : 6'b0;
    held_nxt = do_make ? key_held | hit : do_brk ? key_held & ~hit : key_held;
    kc_nxt = do_make ? rx_data : clr ? 8'h00 : keycode;
    kx_nxt = do_make ? ext : !clr && keycode_ext;
  end
  // sequence state and prefix age
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // registered key interface
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      key <= '0;
      key_held <= '0;
      keycode <= '0;
      keycode_ext <= 1'b0;
    end else begin
      key <= key_nxt;
      key_held <= held_nxt;
      keycode <= kc_nxt;
      keycode_ext <= kx_nxt;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench comparing the decoder against a sequence-level key model
module tb_ps2_key_decoder;
  localparam int T = 8;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [5:0] key, key_held;
  logic [7:0] keycode;
  logic keycode_ext;
  int checks = 0;
  int fails = 0;
  int idle_since = 0;
  logic [20:0] exp_q[$];
  logic [8:0] seq_tab [6] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A, 9'h076};
  logic m_pend, m_ext, m_brk, m_kx;
  logic [5:0] m_held;
  logic [7:0] m_kc;
  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h12, 8'h59, 8'hAA, 8'hFA, 8'hE1, 8'h00, 8'hE0, 8'hF0};

  ps2_key_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .pclk(pclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key(key), .key_held(key_held), .keycode(keycode), .keycode_ext(keycode_ext)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) idle_since <= rx_valid ? 0 : idle_since + 1;

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (key/held/keycode/ext packed) at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] lookup(input logic e, input logic [7:0] c);
    for (int i = 0; i < 6; i++) if (seq_tab[i] == {e, c}) return 6'b1 << i;
    return 6'b0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ext = 0; m_brk = 0; m_kx = 0; m_held = '0; m_kc = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int idle, output logic [20:0] res);
    logic [5:0] hit, pulse;
    pulse = '0;
    if (m_pend && idle >= T) m_pend = 0;
    if (!m_pend) begin
      if (b == 8'hE0) begin m_pend = 1; m_ext = 1; m_brk = 0; end
      else if (b == 8'hF0) begin m_pend = 1; m_ext = 0; m_brk = 1; end
      else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00})) begin
        hit = lookup(1'b0, b);
        pulse = hit & ~m_held; m_held |= hit; m_kc = b; m_kx = 0;
      end
    end else if (m_brk) begin
      hit = lookup(m_ext, b);
      m_held &= ~hit;
      if (b == m_kc && m_ext == m_kx) begin m_kc = 0; m_kx = 0; end
      m_pend = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!(b inside {8'h12, 8'h59})) begin
        hit = lookup(1'b1, b);
        pulse = hit & ~m_held; m_held |= hit; m_kc = b; m_kx = 1;
      end
      m_pend = 0;
    end
    res = {pulse, m_held, m_kc, m_kx};
  endtask

  task automatic send(input logic [7:0] b);
    logic [20:0] e;
    @(negedge pclk);
    model_byte(b, idle_since, e);
    exp_q.push_back(e);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int k);
    repeat (k - 1) @(negedge pclk);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {key, key_held, keycode, keycode_ext}, 21'b0);
    model_reset();
    exp_q.delete();
    @(negedge pclk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic v;
    logic [20:0] e;
    forever begin
      @(posedge pclk);
      v = rx_valid;
      @(negedge pclk);
      if (v) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 21'h1, 21'h0);
        else begin
          e = exp_q.pop_front();
          chk("response", {key, key_held, keycode, keycode_ext}, e);
        end
      end else chk("no_pulse", {15'b0, key}, 21'b0);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge pclk);
    chk("reset_state", {key, key_held, keycode, keycode_ext}, 21'b0);
    rst = 1'b0;
    send(8'h5A); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h6B); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'h5A); send(8'h76); send(8'hF0); send(8'h5A); send(8'hF0); send(8'h76);
    send(8'hE0); gap(8); send(8'h75);
    send(8'hE0); gap(7); send(8'h75);
    send(8'hE0); send(8'hF0); gap(8); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75); send(8'hAA); send(8'hFA);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h75); send(8'hE0);
    do_reset();
    send(8'h72);
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      b = $urandom_range(0, 9) == 0 ? 8'($urandom) : pool[$urandom_range(0, 15)];
      send(b);
      gap($urandom_range(0, 5) == 0 ? $urandom_range(6, 10) : $urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    repeat (3) @(negedge pclk);
    chk("queue_drained", 21'(exp_q.size()), 21'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
